// File: rtl/cla32_nibble_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla32_nibble_serial_pkg
// Brief    : Shared types and constants for the nibble-serial CLA adder.
// Revision : 1.0 - initial release
// ============================================================================
package cla32_nibble_serial_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // One lookahead slice handles a nibble per clock
  localparam int NIBBLE_W      = 4;
  localparam int DEFAULT_WIDTH = 32;

endpackage
`default_nettype wire

// File: rtl/cla4_slice.sv
`default_nettype none
// ============================================================================
// Module   : cla4_slice
// Brief    : Combinational 4-bit carry-lookahead adder slice.
// Revision : 1.0 - initial release
// ============================================================================
module cla4_slice
  import cla32_nibble_serial_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s4,
  output logic                cout
);

  logic [NIBBLE_W-1:0] gen;
  logic [NIBBLE_W-1:0] prop;
  logic [NIBBLE_W:0]   carry;

  assign gen  = a4 & b4;
  assign prop = a4 ^ b4;

  // Every carry is expanded directly from cin, so no carry ripples between bits
  assign carry[0] = cin;
  assign carry[1] = gen[0] | (prop[0] & cin);
  assign carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
  assign carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                  | (prop[2] & prop[1] & prop[0] & cin);
  assign carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                  | (prop[3] & prop[2] & prop[1] & gen[0])
                  | (prop[3] & prop[2] & prop[1] & prop[0] & cin);

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_sum
    assign s4[i] = prop[i] ^ carry[i];
  end

  assign cout = carry[NIBBLE_W];

endmodule
`default_nettype wire

// File: rtl/cla32_nibble_serial.sv
`default_nettype none
// ============================================================================
// Module   : cla32_nibble_serial
// Brief    : WIDTH-bit adder that processes one nibble per clock through a
//            single time-shared 4-bit carry-lookahead slice.
// Revision : 1.0 - initial release
// ============================================================================
module cla32_nibble_serial
  import cla32_nibble_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int            N      = WIDTH / NIBBLE_W;
  localparam int            KW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  state_t               state;
  logic [KW-1:0]        k;
  logic                 carry;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [WIDTH-1:0]     work;
  logic [WIDTH-1:0]     next_work;
  logic [NIBBLE_W-1:0]  nib_a;
  logic [NIBBLE_W-1:0]  nib_b;
  logic [NIBBLE_W-1:0]  nib_s;
  logic                 nib_co;

  assign nib_a = op_a[k*NIBBLE_W +: NIBBLE_W];
  assign nib_b = op_b[k*NIBBLE_W +: NIBBLE_W];

  cla4_slice u_slice (
    .a4   (nib_a),
    .b4   (nib_b),
    .cin  (carry),
    .s4   (nib_s),
    .cout (nib_co)
  );

  // Working register with the current nibble's sum merged in; on the last
  // step this is the complete result that goes straight to s
  always_comb begin
    next_work = work;
    next_work[k*NIBBLE_W +: NIBBLE_W] = nib_s;
  end

  // Sequencer: capture, nibble-serial add, result publish
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      co    <= 1'b0;
      k     <= '0;
      carry <= 1'b0;
      work  <= '0;
      op_a  <= '0;
      op_b  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= ci;
            k     <= '0;
            state <= EXEC;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        EXEC: begin
          // start is deliberately not looked at here
          work  <= next_work;
          carry <= nib_co;
          if (k == K_LAST) begin
            // k parks at N-1; only a new capture returns it to 0
            s     <= next_work;
            co    <= nib_co;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cla32_nibble_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla32_nibble_serial
// Brief    : Self-checking bench for cla32_nibble_serial (WIDTH = 32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla32_nibble_serial;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;

  logic [WIDTH:0]   exp_q[$];
  int               compared;
  int               mismatched;

  cla32_nibble_serial #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .ci      (ci),
    .busy    (busy),
    .done    (done),
    .s       (s),
    .co      (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation and wait for its done pulse. b2b=1 means the caller
  // is already sitting in the DONE cycle, so start is driven without waiting.
  // inject=1 raises start with other operands during EXEC cycle 3.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] ta,
                        input logic [WIDTH-1:0] tb, input logic tci,
                        input bit b2b, input bit inject);
    logic [WIDTH-1:0] prev_s;
    logic             prev_co;
    logic [WIDTH:0]   exp;
    int               edges;
    int               busy_cycles;
    bit               stable;
    if (!b2b) @(negedge clk);
    a = ta; b = tb; ci = tci; start = 1'b1;
    exp_q.push_back({1'b0, ta} + {1'b0, tb} + {{WIDTH{1'b0}}, tci});
    prev_s  = s;
    prev_co = co;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; ci = 1'($urandom);
    busy_cycles = 0;
    stable = 1'b1;
    while (!done && edges < 20) begin
      if (busy) busy_cycles++;
      if (s !== prev_s || co !== prev_co) stable = 1'b0;
      if (inject && edges == 3) begin
        start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1234_5678; ci = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_latency"}, 64'(edges), 64'd9);
    check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd8);
    check({tag, "_stable"}, {63'd0, stable}, 64'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_sum"}, {31'd0, co, s}, {31'd0, exp});
    end
  endtask

  initial begin
    bit saw_done;
    compared   = 0;
    mismatched = 0;
    reset_n = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_s",    {32'd0, s},    64'd0);
    check("rst_co",   {63'd0, co},   64'd0);
    reset_n = 1'b1;

    // Full carry ripple through every nibble
    run_op("ovf", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("ovf_done_pulse", {63'd0, done}, 64'd0);
    check("ovf_idle_busy",  {63'd0, busy}, 64'd0);

    run_op("pat", 32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of EXEC
    @(negedge clk);
    a = 32'hAAAA_AAAA; b = 32'h5555_5555; ci = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_s",    {32'd0, s},    64'd0);
    check("abort_co",   {63'd0, co},   64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", {63'd0, saw_done}, 64'd0);

    run_op("cin", 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0);

    // start during EXEC is ignored
    run_op("ignore", 32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, 1'b1);

    // Back-to-back through DONE
    run_op("b2b_first",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    run_op("b2b_second", 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 1000; i++) begin
      run_op("rand", $urandom, $urandom, 1'($urandom), 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
